// File: rtl/reg_cmd_sequencer.sv
// Command-stream sequencer for the register block: decodes header/address/data words into
// reg_num_le/wr_en/rd_en pulses and returns readback and status words. CMD_TIMEOUT_EN enables the idle timeout.
module reg_cmd_sequencer
`ifdef CMD_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] reg_rx_data,
    output logic        reg_num_le,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    input  logic        illegal_reg_num,
    input  logic [31:0] reg_tx_data,
    output logic        busy,
    output logic [7:0]  err_count
);

    typedef enum logic [3:0] {
        IDLE, ADDR, LATCH, CHECK, WDATA, DRAIN, RD_ISSUE, RD_WAIT, RD_SEND, STATUS
    } state_e;

    state_e      state_q, state_d;
    logic        is_read_q, is_read_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  beat_q, beat_d;
    logic [7:0]  err_q, err_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [31:0] rx_q, rx_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        num_le_q, num_le_d;
    logic        wr_en_q, wr_en_d;
    logic        rd_en_q, rd_en_d;
    logic        accept;
    logic [7:0]  beat_next;

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q, timer_d;
`endif

    function automatic logic [31:0] status_word(input logic [3:0] code, input logic [7:0] n);
        return {8'hA5, 4'h0, code, 8'h00, n};
    endfunction

    // Gated by reset so every output reads 0 while reset is held, even though IDLE accepts.
    assign cmd_ready   = reset && (state_q inside {IDLE, ADDR, WDATA, DRAIN});
    assign accept      = cmd_valid && cmd_ready;
    assign beat_next   = beat_q + 8'd1;
    assign rsp_data    = rsp_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign reg_rx_data = rx_q;
    assign reg_num_le  = num_le_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_rd_en   = rd_en_q;
    assign busy        = (state_q != IDLE);
    assign err_count   = err_q;

    always_comb begin
        state_d     = state_q;
        is_read_d   = is_read_q;
        cnt_d       = cnt_q;
        beat_d      = beat_q;
        err_d       = err_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        rx_d        = rx_q;
        num_le_d    = 1'b0;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d     = cmd_data[7:0];
                    beat_d    = 8'd0;
                    is_read_d = (cmd_data[31:30] == 2'b10);
                    if (cmd_data[31:30] == 2'b11) begin
                        state_d     = STATUS;
                        rsp_data_d  = status_word(4'd1, cmd_data[7:0]);
                        rsp_valid_d = 1'b1;
                    end else if (cmd_data[31:30] != 2'b00) begin
                        if (cmd_data[7:0] == 8'd0) begin
                            state_d     = STATUS;
                            rsp_data_d  = status_word(4'd4, 8'd0);
                            rsp_valid_d = 1'b1;
                        end else begin
                            state_d = ADDR;
                        end
                    end
                end
            end
            ADDR: begin
                if (accept) begin
                    rx_d     = cmd_data;
                    num_le_d = 1'b1;
                    state_d  = LATCH;
                end
            end
            LATCH: state_d = CHECK;
            CHECK: begin
                if (illegal_reg_num) begin
                    if (is_read_q) begin
                        state_d     = STATUS;
                        rsp_data_d  = status_word(4'd2, cnt_q);
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    state_d = is_read_q ? RD_ISSUE : WDATA;
                end
            end
            WDATA, DRAIN: begin
                if (accept) begin
                    rx_d    = cmd_data;
                    wr_en_d = (state_q == WDATA);
                    beat_d  = beat_next;
                    if (beat_next == cnt_q) begin
                        state_d     = STATUS;
                        rsp_data_d  = status_word((state_q == WDATA) ? 4'd0 : 4'd2, cnt_q);
                        rsp_valid_d = 1'b1;
                    end
                end
            end
            RD_ISSUE: begin
                rd_en_d = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: state_d = RD_SEND;
            // First cycle captures the readback word, later cycles wait for the handshake.
            RD_SEND: begin
                if (!rsp_valid_q) begin
                    rsp_data_d  = reg_tx_data;
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    beat_d      = beat_next;
                    if (beat_next == cnt_q) begin
                        state_d     = STATUS;
                        rsp_data_d  = status_word(4'd0, cnt_q);
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            STATUS: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                    if (rsp_data_q[19:16] != 4'd0 && err_q != 8'hFF)
                        err_d = err_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef CMD_TIMEOUT_EN
        timer_d = '0;
        if (state_q inside {ADDR, WDATA, DRAIN} && !accept) begin
            if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d     = STATUS;
                rsp_data_d  = status_word(4'd3, cnt_q);
                rsp_valid_d = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            is_read_q   <= 1'b0;
            cnt_q       <= 8'd0;
            beat_q      <= 8'd0;
            err_q       <= 8'd0;
            rsp_data_q  <= 32'd0;
            rsp_valid_q <= 1'b0;
            rx_q        <= 32'd0;
            num_le_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            is_read_q   <= is_read_d;
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            rx_q        <= rx_d;
            num_le_q    <= num_le_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
`ifdef CMD_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Directed self-checking bench for reg_cmd_sequencer with a small behavioural register block
// (registers 0-15 legal, anything above is illegal).
module tb_reg_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cmd_data = 32'd0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] reg_rx_data;
    logic        reg_num_le;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic        illegal_reg_num;
    logic [31:0] reg_tx_data = 32'd0;
    logic        busy;
    logic [7:0]  err_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] regMem [0:15];
    logic [31:0] regNum = 32'd0;
    int          wrCount = 0;
    int          rdCount = 0;
    logic [31:0] wrLog [$];
    logic [31:0] wrRegLog [$];

    always #4 clk = ~clk;

`ifdef CMD_TIMEOUT_EN
    reg_cmd_sequencer #(.TIMEOUT_CYCLES(16)) dut (
`else
    reg_cmd_sequencer dut (
`endif
        .clk(clk), .reset(reset),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .reg_rx_data(reg_rx_data), .reg_num_le(reg_num_le),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
        .illegal_reg_num(illegal_reg_num), .reg_tx_data(reg_tx_data),
        .busy(busy), .err_count(err_count)
    );

    // Register block model: latches reg_num, writes on wr_en, answers rd_en one cycle later.
    assign illegal_reg_num = (regNum >= 32'd16);

    initial for (int i = 0; i < 16; i++) regMem[i] = 32'd0;

    always @(posedge clk) begin
        if (reg_num_le) regNum <= reg_rx_data;
        if (reg_wr_en) begin
            wrCount <= wrCount + 1;
            wrLog.push_back(reg_rx_data);
            wrRegLog.push_back(regNum);
            if (regNum < 32'd16) regMem[regNum[3:0]] <= reg_rx_data;
        end
        if (reg_rd_en) begin
            rdCount <= rdCount + 1;
            reg_tx_data <= regMem[regNum[3:0]];
        end
    end

    // Called at a negedge; returns at the negedge after the word was accepted.
    task automatic sendWord(input logic [31:0] w);
        int n = 0;
        cmd_data  = w;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL cmd_accept_timeout: word %h not accepted after %0d cycles", w, n);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitRsp(output logic [31:0] d);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (rsp_valid !== 1'b1) begin
            checks++; failures++;
            $display("FAIL rsp_timeout: no response after %0d cycles", n);
            d = 32'd0;
        end else begin
            d = rsp_data;
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if ({cmd_ready, rsp_valid, reg_num_le, reg_wr_en, reg_rd_en, busy} !== 6'b0) begin failures++; $display("FAIL reset_ctrl: got %b required 000000", {cmd_ready, rsp_valid, reg_num_le, reg_wr_en, reg_rd_en, busy}); end
        checks++; if ({rsp_data, reg_rx_data, err_count} !== 72'd0) begin failures++; $display("FAIL reset_data: got %h required 0", {rsp_data, reg_rx_data, err_count}); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset: ready=%b busy=%b required 1/0", cmd_ready, busy); end
    endtask

    task automatic test_write_read();
        logic [31:0] r;
        int wr0 = wrCount, rd0 = rdCount;
        sendWord(32'h4000_0001); sendWord(32'd5); sendWord(32'hDEAD_BEEF);
        waitRsp(r);
        checks++; if (r !== 32'hA500_0001) begin failures++; $display("FAIL wr1_status: got %h required A5000001", r); end
        checks++; if (wrCount - wr0 !== 1) begin failures++; $display("FAIL wr1_pulses: got %0d required 1", wrCount - wr0); end
        checks++; if (reg_rx_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr1_rx_data: got %h required DEADBEEF", reg_rx_data); end
        sendWord(32'h8000_0001); sendWord(32'd5);
        waitRsp(r);
        checks++; if (r !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd1_data: got %h required DEADBEEF", r); end
        waitRsp(r);
        checks++; if (r !== 32'hA500_0001) begin failures++; $display("FAIL rd1_status: got %h required A5000001", r); end
        checks++; if (rdCount - rd0 !== 1) begin failures++; $display("FAIL rd1_pulses: got %0d required 1", rdCount - rd0); end
        checks++; if (err_count !== 8'd0 || busy !== 1'b0) begin failures++; $display("FAIL rd1_idle: err=%0d busy=%b required 0/0", err_count, busy); end
    endtask

    task automatic test_latency();
        logic [31:0] r;
        sendWord(32'h4000_0001);
        cmd_data = 32'd3; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_data = 32'h0000_5A5A;
        checks++; if (reg_num_le !== 1'b1 || cmd_ready !== 1'b0 || reg_rx_data !== 32'd3) begin failures++; $display("FAIL lat_latch: le=%b ready=%b rx=%h required 1/0/3", reg_num_le, cmd_ready, reg_rx_data); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b0 || reg_wr_en !== 1'b0 || reg_num_le !== 1'b0) begin failures++; $display("FAIL lat_check: ready=%b wr=%b le=%b required 0/0/0", cmd_ready, reg_wr_en, reg_num_le); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || reg_wr_en !== 1'b0) begin failures++; $display("FAIL lat_wdata: ready=%b wr=%b required 1/0", cmd_ready, reg_wr_en); end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (reg_wr_en !== 1'b1 || reg_rx_data !== 32'h0000_5A5A) begin failures++; $display("FAIL lat_first_wr: wr=%b rx=%h required 1/00005A5A", reg_wr_en, reg_rx_data); end
        waitRsp(r);
        checks++; if (r !== 32'hA500_0001) begin failures++; $display("FAIL lat_status: got %h required A5000001", r); end
    endtask

    task automatic test_burst_write();
        logic [31:0] r;
        logic [31:0] expData [3] = '{32'h11, 32'h22, 32'h33};
        int base = wrLog.size();
        sendWord(32'h4000_0003); sendWord(32'd14);
        for (int i = 0; i < 3; i++) sendWord(expData[i]);
        waitRsp(r);
        checks++; if (r !== 32'hA500_0003) begin failures++; $display("FAIL burst_status: got %h required A5000003", r); end
        checks++; if (wrLog.size() - base !== 3) begin failures++; $display("FAIL burst_pulses: got %0d required 3", wrLog.size() - base); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (wrLog[base+i] !== expData[i] || wrRegLog[base+i] !== 32'd14) begin failures++; $display("FAIL burst_beat%0d: data=%h reg=%0d required %h/14", i, wrLog[base+i], wrRegLog[base+i], expData[i]); end
            end
        end
    endtask

    task automatic test_illegal_reg();
        logic [31:0] r;
        int wr0 = wrCount, rd0 = rdCount;
        sendWord(32'h8000_0002); sendWord(32'h10);
        waitRsp(r);
        checks++; if (r !== 32'hA502_0002) begin failures++; $display("FAIL illegal_rd_status: got %h required A5020002", r); end
        checks++; if (rdCount !== rd0) begin failures++; $display("FAIL illegal_rd_pulses: got %0d required 0", rdCount - rd0); end
        checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL illegal_rd_err: got %0d required 1", err_count); end
        sendWord(32'h4000_0002); sendWord(32'h10); sendWord(32'hAAAA_0001); sendWord(32'hAAAA_0002);
        waitRsp(r);
        checks++; if (r !== 32'hA502_0002) begin failures++; $display("FAIL drain_status: got %h required A5020002", r); end
        checks++; if (wrCount !== wr0) begin failures++; $display("FAIL drain_pulses: got %0d required 0", wrCount - wr0); end
        checks++; if (err_count !== 8'd2) begin failures++; $display("FAIL drain_err: got %0d required 2", err_count); end
    endtask

    task automatic test_bad_header();
        logic [31:0] r;
        sendWord(32'hC000_0007);
        waitRsp(r);
        checks++; if (r !== 32'hA501_0007) begin failures++; $display("FAIL badop_status: got %h required A5010007", r); end
        sendWord(32'h4000_0000);
        waitRsp(r);
        checks++; if (r !== 32'hA504_0000) begin failures++; $display("FAIL zerocnt_status: got %h required A5040000", r); end
        checks++; if (err_count !== 8'd4) begin failures++; $display("FAIL hdr_err: got %0d required 4", err_count); end
        sendWord(32'h0000_0005);
        for (int i = 0; i < 8; i++) begin
            checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL nop_idle%0d: valid=%b busy=%b required 0/0", i, rsp_valid, busy); end
            @(negedge clk);
        end
    endtask

    task automatic test_read_stall();
        logic [31:0] r;
        int n;
        int rd0 = rdCount;
        sendWord(32'h8000_0004); sendWord(32'd5);
        for (int w = 0; w < 4; w++) begin
            n = 0;
            while (rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            for (int s = 0; s < 10; s++) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL stall_w%0d_s%0d: valid=%b data=%h required 1/DEADBEEF", w, s, rsp_valid, rsp_data); end
                @(negedge clk);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        waitRsp(r);
        checks++; if (r !== 32'hA500_0004) begin failures++; $display("FAIL stall_status: got %h required A5000004", r); end
        checks++; if (rdCount - rd0 !== 4) begin failures++; $display("FAIL stall_rd_pulses: got %0d required 4", rdCount - rd0); end
    endtask

`ifdef CMD_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] r;
        sendWord(32'h4000_0004); sendWord(32'd6); sendWord(32'h1); sendWord(32'h2);
        waitRsp(r);
        checks++; if (r !== 32'hA503_0004) begin failures++; $display("FAIL timeout_status: got %h required A5030004", r); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_idle: busy=%b required 0", busy); end
    endtask
`endif

    task automatic test_reset_mid_burst();
        logic [31:0] r;
        int wr0;
        sendWord(32'h4000_0004); sendWord(32'd7); sendWord(32'hA1); sendWord(32'hA2);
        repeat (2) @(negedge clk);
        wr0 = wrCount;
        #2 reset = 1'b0;
        #1;
        checks++; if ({cmd_ready, rsp_valid, reg_num_le, reg_wr_en, reg_rd_en, busy} !== 6'b0) begin failures++; $display("FAIL midreset_ctrl: got %b required 000000", {cmd_ready, rsp_valid, reg_num_le, reg_wr_en, reg_rd_en, busy}); end
        checks++; if ({rsp_data, reg_rx_data, err_count} !== 72'd0) begin failures++; $display("FAIL midreset_data: got %h required 0", {rsp_data, reg_rx_data, err_count}); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (wrCount !== wr0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midreset_quiet: wr=%0d valid=%b busy=%b required 0/0/0", wrCount - wr0, rsp_valid, busy); end
        sendWord(32'h4000_0001); sendWord(32'd2); sendWord(32'h0BAD_F00D);
        waitRsp(r);
        checks++; if (r !== 32'hA500_0001) begin failures++; $display("FAIL postreset_status: got %h required A5000001", r); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_latency();
        test_burst_write();
        test_illegal_reg();
        test_bad_header();
        test_read_stall();
`ifdef CMD_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
